cursor_ctrl: RTL
================

# cursor_ctrl

Consumes the single-cycle press pulses produced by the button front end and turns them into a cursor position on the Game of Life board, plus a cell-toggle write request toward board storage. Owns cursor row/column with wrap-around, a blink signal for the display path, and a req/ack handshake so a toggle is written exactly once. Sits between the per-button one-pulse stages and the board memory/display logic. It is active only while the simulation is paused.

## Interface
- ROWS, 16, board height in cells (≥2)
- COLS, 16, board width in cells (≥2)
- BLINK_CYCLES, 25_000_000, cycles per cursor_on half-period (≥2)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- up, down, left, right  in  1 each  single-cycle move pulses
- toggle  in  1  single-cycle pulse: invert cell under cursor
- run  in  1  1 = simulation running; user edits locked out
- row  out  $clog2(ROWS)  cursor row
- col  out  $clog2(COLS)  cursor column
- cursor_on  out  1  blink phase; display highlights cursor cell when 1
- wr_req  out  1  toggle request to board storage, held until acked
- wr_row  out  $clog2(ROWS)  row to toggle, stable while wr_req=1
- wr_col  out  $clog2(COLS)  column to toggle, stable while wr_req=1
- wr_ack  in  1  storage accepted request (sampled only while wr_req=1)

## Operation
- Reset values: row=0, col=0, cursor_on=1, wr_req=0, wr_row=0, wr_col=0, blink counter=0, state IDLE.
- States: IDLE (edits accepted), REQ (toggle pending).
- IDLE, run=0, toggle=1: latch wr_row/wr_col from current row/col, wr_req=1, go REQ. Any move pulses in the same cycle are dropped (toggle wins).
- IDLE, run=0, toggle=0: apply moves. up: row−1; down: row+1; left: col−1; right: col+1.
- up&down together: row unchanged. left&right together: col unchanged. One vertical plus one horizontal: both applied same cycle (diagonal).
- Wrap: row 0 up → ROWS−1; row ROWS−1 down → 0; same for col with COLS. Arithmetic in index width, explicit compare against bounds (non-power-of-two sizes must wrap correctly).
- REQ: all move/toggle pulses ignored; row/col frozen. wr_ack=1 → wr_req=0 next cycle, go IDLE.
- wr_ack while IDLE: ignored.
- run=1: moves and toggles ignored; cursor_on forced 0; blink counter held at 0. A REQ in progress still completes on wr_ack.
- run 1→0: cursor_on=1 next cycle, counter restarts from 0.
- Blink: counter counts 0..BLINK_CYCLES−1; on reaching BLINK_CYCLES−1, counter→0 and cursor_on inverts. Any accepted move clears counter and sets cursor_on=1 (cursor visible immediately after moving).
- Reset mid-REQ: wr_req drops to 0 next edge, no write issued; position returns to (0,0).

## Timing
- All outputs registered; no combinational input→output paths.
- Move pulse at edge N → new row/col visible after edge N.
- Toggle at edge N → wr_req=1 after N; wr_ack sampled at edge M → wr_req=0 after M. Minimum REQ occupancy 1 cycle (ack may be high the first cycle wr_req is high).
- Back-to-back: toggle accepted the cycle after wr_req falls.

## Structure
- Shared package game_pkg: ROWS/COLS defaults, cursor_state_e enum {IDLE, REQ}.
- Sub-module blink_timer (params BLINK_CYCLES; inputs clk, reset, hold, restart; output phase) owns counter and cursor_on; top holds FSM, position and handshake.

## Test plan
- ROWS=COLS=5, BLINK_CYCLES=4: reset → row=0, col=0, cursor_on=1, wr_req=0.
- From (0,0): up pulse → (4,0); left → (4,4); down → (0,4); right → (0,0); up+down same cycle → row unchanged; up+right → (4,1).
- At (2,3): toggle → wr_req=1, wr_row=2, wr_col=3; moves during REQ leave (2,3); wr_ack after 3 cycles → wr_req=0 next cycle; exactly one request observed.
- Toggle+right same cycle at (1,1) → request for (1,1), cursor stays (1,1).
- No input: cursor_on toggles every 4 cycles; move mid-period → cursor_on=1, next flip 4 cycles later; run=1 → cursor_on=0, pulses ignored, position unchanged.
- Reset asserted during REQ → wr_req=0, (0,0), cursor_on=1 next cycle; late wr_ack ignored.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the Game of Life board editing logic.
package game_pkg;

  localparam int DEFAULT_ROWS         = 16;
  localparam int DEFAULT_COLS         = 16;
  localparam int DEFAULT_BLINK_CYCLES = 25_000_000;

  // Cursor editing FSM: IDLE accepts edits, REQ waits for storage to ack a toggle.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } cursor_state_e;

endpackage

// File: rtl/cursor_ctrl_blink_timer.sv
// Blink phase generator for the cursor highlight. Holds dark while the
// simulation runs; restarts visible whenever the cursor moves or editing resumes.
module blink_timer
  import game_pkg::*;
#(
  parameter int BLINK_CYCLES = DEFAULT_BLINK_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic restart,
  output logic phase
);

  localparam int            CNT_W    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Next counter/phase: hold beats restart, restart beats normal counting.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (hold) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter and phase registers; cursor starts visible out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/cursor_ctrl.sv
// Cursor position, toggle write handshake and blink for board editing while paused.
module cursor_ctrl
  import game_pkg::*;
#(
  parameter int ROWS         = DEFAULT_ROWS,
  parameter int COLS         = DEFAULT_COLS,
  parameter int BLINK_CYCLES = DEFAULT_BLINK_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    up,
  input  logic                    down,
  input  logic                    left,
  input  logic                    right,
  input  logic                    toggle,
  input  logic                    run,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [$clog2(COLS)-1:0] col,
  output logic                    cursor_on,
  output logic                    wr_req,
  output logic [$clog2(ROWS)-1:0] wr_row,
  output logic [$clog2(COLS)-1:0] wr_col,
  input  logic                    wr_ack
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  cursor_state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d, wr_row_q, wr_row_d;
  logic [CW-1:0] col_q, col_d, wr_col_q, wr_col_d;
  logic          wr_req_q, wr_req_d;
  logic          run_q, run_d;
  logic          move_accept;
  logic          blink_restart;
  logic [RW-1:0] row_inc, row_dec;
  logic [CW-1:0] col_inc, col_dec;

  // Wrapped neighbours; explicit bound compares keep non-power-of-two sizes correct.
  always_comb begin
    row_inc = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
    row_dec = (row_q == '0) ? ROW_LAST : row_q - RW'(1);
    col_inc = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
    col_dec = (col_q == '0) ? COL_LAST : col_q - CW'(1);
  end

  // Editing FSM: toggle launches a request (and swallows same-cycle moves),
  // otherwise moves are applied; REQ freezes everything until the ack.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    wr_req_d    = wr_req_q;
    wr_row_d    = wr_row_q;
    wr_col_d    = wr_col_q;
    run_d       = run;
    move_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (!run) begin
          if (toggle) begin
            wr_row_d = row_q;
            wr_col_d = col_q;
            wr_req_d = 1'b1;
            state_d  = REQ;
          end else begin
            move_accept = up | down | left | right;
            if (up && !down) begin
              row_d = row_dec;
            end else if (down && !up) begin
              row_d = row_inc;
            end
            if (left && !right) begin
              col_d = col_dec;
            end else if (right && !left) begin
              col_d = col_inc;
            end
          end
        end
      end
      REQ: begin
        if (wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        wr_req_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // Blink restarts on any accepted move and when editing resumes after a run.
  assign blink_restart = move_accept | (run_q & ~run);

  // State, position and handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      wr_req_q <= 1'b0;
      wr_row_q <= '0;
      wr_col_q <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      wr_req_q <= wr_req_d;
      wr_row_q <= wr_row_d;
      wr_col_q <= wr_col_d;
      run_q    <= run_d;
    end
  end

  blink_timer #(
    .BLINK_CYCLES(BLINK_CYCLES)
  ) u_blink (
    .clk     (clk),
    .reset   (reset),
    .hold    (run),
    .restart (blink_restart),
    .phase   (cursor_on)
  );

  assign row    = row_q;
  assign col    = col_q;
  assign wr_req = wr_req_q;
  assign wr_row = wr_row_q;
  assign wr_col = wr_col_q;

endmodule
